// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   - ISA widths used across the codebase (instruction, opcode, register address).
//   - fetch_state_e: fetch unit state encoding (IDLE/RUN/DRAIN/DONE), also
//     imported by the bench.
//   - slot_free(): read-issue rule for the 2-entry fetch buffer.
package instr_fetch_pkg;

    localparam int INSTRUCTION_WIDTH = 8;
    localparam int OPCODE_WIDTH      = 4;
    localparam int REG_ADDR_WIDTH    = 2;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_DRAIN = 2'd2,
        FETCH_DONE  = 2'd3
    } fetch_state_e;

    // A new read may issue only if the buffered words plus the word in flight,
    // less the word leaving this cycle, leave room for one more.
    function automatic logic slot_free(input logic [1:0] count,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'd2;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus bundle: instruction-memory read port plus the valid/ready
// instruction stream to the decoder.
//   master (fetch unit): drives imem_re, imem_addr, instr, instr_valid;
//                        receives imem_rdata, instr_ready.
//   slave  (memory/decoder side): the mirror image.
// Parameters: INSTR_W instruction width, PC_W address width.
interface instr_fetch_if #(
    parameter int INSTR_W = 8,
    parameter int PC_W    = 8
);
    logic               imem_re;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output imem_re, imem_addr, instr, instr_valid,
        input  imem_rdata, instr_ready
    );

    modport slave (
        input  imem_re, imem_addr, instr, instr_valid,
        output imem_rdata, instr_ready
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO holding fetched instruction words.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (clears storage too)
//   push_i/din_i write a word
//   pop_i        remove the head word
//   head_o       head word (storage contents when empty; 0 after reset)
//   count_o      occupancy 0..2
//   empty_o      no words held
module fetch_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o,
    output logic         empty_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         full;
    logic         pop_ok;
    logic         push_ok;

    assign full    = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign pop_ok  = pop_i & ~empty_o;
    // A simultaneous pop frees the slot the push needs.
    assign push_ok = push_i & (~full | pop_ok);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The fetch unit's issue rule guarantees the buffer is never overrun.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(push_i && full && !pop_i));

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: reads program words 0..last_addr from a synchronous instruction
// memory (1-cycle latency) and streams them to the decoder over valid/ready,
// buffering through a 2-entry FIFO so stalls never drop or duplicate words.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         begin a run from address 0 (accepted only when idle)
//   last_addr     final instruction address, latched when start is accepted
//   busy          high while running or draining
//   done          one-cycle pulse after the last word is accepted
//   stall_cycles  (FETCH_STALL_CNT_EN only) saturating count of cycles with
//                 instr_valid high and instr_ready low since start
//   bus           memory read port and instruction stream (instr_fetch_if)
// Build option: define FETCH_STALL_CNT_EN to add the stall_cycles counter.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int INSTR_W = INSTRUCTION_WIDTH,
    parameter int PC_W    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] last_addr,
    output logic            busy,
    output logic            done,
`ifdef FETCH_STALL_CNT_EN
    output logic [15:0]     stall_cycles,
`endif
    instr_fetch_if.master   bus
);
    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] last_q, last_d;
    logic            inflight_q, inflight_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [INSTR_W-1:0] head;
    logic [1:0]         count;
    logic               empty;
    logic               pop;
    logic               issue;
    logic               drained;

    fetch_fifo #(.W(INSTR_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .din_i   (bus.imem_rdata),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .empty_o (empty)
    );

    assign bus.instr       = head;
    assign bus.instr_valid = ~empty;
    assign pop             = ~empty & bus.instr_ready;

    assign issue         = (state_q == FETCH_RUN) && slot_free(count, inflight_q, pop);
    assign bus.imem_re   = issue;
    assign bus.imem_addr = pc_q;

    // Buffer will be empty after this edge with nothing left to arrive, so
    // done lands in the cycle right after the final accept.
    assign drained = ~inflight_q && ((count == 2'd0) || (count == 2'd1 && pop));

    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        last_d     = last_q;
        inflight_d = issue;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (start) begin
                    last_d  = last_addr;
                    pc_d    = '0;
                    busy_d  = 1'b1;
                    state_d = FETCH_RUN;
                end
            end
            FETCH_RUN: begin
                if (issue) begin
                    // pc holds at last_addr rather than wrapping past the top.
                    if (pc_q == last_q) begin
                        state_d = FETCH_DRAIN;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            FETCH_DRAIN: begin
                if (drained) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FETCH_DONE;
                end
            end
            FETCH_DONE: begin
                state_d = FETCH_IDLE;
            end
            default: begin
                state_d = FETCH_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= '0;
            last_q     <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            last_q     <= last_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == FETCH_IDLE && start) begin
            stall_d = '0;
        end else if (bus.instr_valid && !bus.instr_ready && stall_q != '1) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
